// File: rtl/instr_queue_mp.sv
// Multi-port in-order instruction queue: sparse-mask compacting enqueue and variable in-order dequeue.
// Define IQ_SAME_CYCLE_FREE_EN so that enq_ready also counts the slots freed by this cycle's dequeue.
module instr_queue_mp #(
    parameter int DEPTH  = 16,
    parameter int ENQ_W  = 8,
    parameter int DEQ_W  = 2,
    parameter int DATA_W = 64
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            flush,
    input  logic                            enq_valid,
    input  logic [ENQ_W-1:0]                enq_mask,
    input  logic [ENQ_W-1:0][DATA_W-1:0]    enq_data,
    output logic                            enq_ready,
    output logic [DEQ_W-1:0]                deq_valid,
    output logic [DEQ_W-1:0][DATA_W-1:0]    deq_data,
    input  logic [$clog2(DEQ_W+1)-1:0]      deq_count,
    output logic [$clog2(DEPTH):0]          count,
    output logic [$clog2(DEPTH):0]          free
);

    localparam int INDEX_W = $clog2(DEPTH);
    localparam int PTR_W   = INDEX_W + 1;

    logic [DATA_W-1:0] slots      [DEPTH];
    logic [DATA_W-1:0] slots_next [DEPTH];
    logic [PTR_W-1:0]  head, tail, head_next, tail_next;
    logic [PTR_W-1:0]  push_cnt, eff;
    logic [PTR_W-1:0]  lane_off [ENQ_W];
    logic [INDEX_W-1:0] vidx, widx, ridx;
    logic              enq_fire;

    assign count = tail - head;
    assign free  = PTR_W'(DEPTH) - count;

    // Each set lane lands at tail plus the number of set lanes below it.
    always_comb begin
        push_cnt = '0;
        for (int l = 0; l < ENQ_W; l++) begin
            lane_off[l] = push_cnt;
            if (enq_mask[l]) push_cnt = push_cnt + PTR_W'(1);
        end
    end

    always_comb begin
        eff = PTR_W'(deq_count);
        if (eff > count) eff = count;
        if (eff > PTR_W'(DEQ_W)) eff = PTR_W'(DEQ_W);
    end

`ifdef IQ_SAME_CYCLE_FREE_EN
    assign enq_ready = ((free + eff) >= push_cnt);
`else
    assign enq_ready = (free >= push_cnt);
`endif

    assign enq_fire = enq_valid & enq_ready & ~flush;

    // Vacated slots are cleared before the enqueue writes, so same-cycle reuse keeps the new data.
    always_comb begin
        slots_next = slots;
        head_next  = head + eff;
        tail_next  = tail;
        vidx       = '0;
        widx       = '0;
        for (int i = 0; i < DEQ_W; i++) begin
            if (PTR_W'(i) < eff) begin
                vidx = head[INDEX_W-1:0] + INDEX_W'(i);
                slots_next[vidx] = '0;
            end
        end
        if (enq_fire) begin
            tail_next = tail + push_cnt;
            for (int l = 0; l < ENQ_W; l++) begin
                if (enq_mask[l]) begin
                    widx = tail[INDEX_W-1:0] + lane_off[l][INDEX_W-1:0];
                    slots_next[widx] = enq_data[l];
                end
            end
        end
        if (flush) begin
            head_next = head;
            tail_next = head;
            for (int s = 0; s < DEPTH; s++) slots_next[s] = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head <= '0;
            tail <= '0;
            for (int s = 0; s < DEPTH; s++) slots[s] <= '0;
        end else begin
            head  <= head_next;
            tail  <= tail_next;
            slots <= slots_next;
        end
    end

    always_comb begin
        ridx = '0;
        for (int i = 0; i < DEQ_W; i++) begin
            ridx         = head[INDEX_W-1:0] + INDEX_W'(i);
            deq_valid[i] = (count > PTR_W'(i));
            deq_data[i]  = deq_valid[i] ? slots[ridx] : '0;
        end
    end

endmodule
